// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write port arbiter: widths,
// the write-request record and the arbitration state encoding.
package regfile_write_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wr_req_t;

   typedef enum logic [0:0] {
      NORMAL = 1'b0,
      FORCE  = 1'b1
   } arb_state_e;

   localparam wr_req_t WR_REQ_NONE = '{addr: 5'd0, data: 32'h0000_0000};

   // Register 0 is hard-wired; a request to it is consumed but never written.
   function automatic logic writes_reg(input wr_req_t req);
      return (req.addr != REG_ZERO);
   endfunction

   function automatic wr_req_t squash_zero(input wr_req_t req);
      wr_req_t res;
      if (writes_reg(req)) begin
         res = req;
      end else begin
         res = WR_REQ_NONE;
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_result_fifo.sv
// Small circular FIFO holding long-latency results until they win the
// register-file write port. Head is valid one cycle after the push.
module regfile_write_arbiter_result_fifo
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  wr_req_t          i_push_req,
   input  logic             i_pop,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count,
   output wr_req_t          o_head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   wr_req_t          r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == CNT_ZERO);
   assign w_full    = (r_count == CNT_FULL);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~w_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Storage array; pointers are power-of-two wide so they wrap naturally.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= WR_REQ_NONE;
         end
      end else if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_req;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr <= PTR_ZERO;
         r_rd_ptr <= PTR_ZERO;
         r_count  <= CNT_ZERO;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the writeback stage
// (priority) and queued long-latency results, with a starvation guard.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         i_wb_valid,
   input  logic [REG_ADDR_W-1:0]        i_wb_addr,
   input  logic [DATA_W-1:0]            i_wb_data,
   output logic                         o_stall_wb,
   input  logic                         i_lu_valid,
   input  logic [REG_ADDR_W-1:0]        i_lu_addr,
   input  logic [DATA_W-1:0]            i_lu_data,
   output logic                         o_lu_ready,
   output logic                         o_rf_we,
   output logic [REG_ADDR_W-1:0]        o_rf_waddr,
   output logic [DATA_W-1:0]            o_rf_wdata,
   output logic [$clog2(DEPTH+1)-1:0]   o_fifo_count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [STV_W-1:0] STV_ZERO = {STV_W{1'b0}};
   localparam logic [STV_W-1:0] STV_ONE  = {{(STV_W-1){1'b0}}, 1'b1};
   localparam logic [STV_W-1:0] STV_TRIP = STV_W'(STARVE_LIMIT - 1);

   arb_state_e       r_state;
   arb_state_e       w_state_nxt;
   logic [STV_W-1:0] r_starve;
   logic [STV_W-1:0] w_starve_nxt;
   logic [STV_W-1:0] w_starve_inc;
   logic             r_stall_wb;
   logic             w_stall_nxt;

   logic             w_wb_accept;
   wr_req_t          w_wb_req;
   wr_req_t          w_lu_req;
   logic             w_push;
   logic             w_pop;
   logic             w_fifo_empty;
   logic [CNT_W-1:0] w_fifo_count;
   wr_req_t          w_fifo_head;
   logic             w_grant;
   wr_req_t          w_grant_req;
   wr_req_t          w_out_req;

   assign w_wb_accept  = i_wb_valid & ~r_stall_wb;
   assign w_wb_req     = '{addr: i_wb_addr, data: i_wb_data};
   assign w_lu_req     = '{addr: i_lu_addr, data: i_lu_data};
   assign o_lu_ready   = (w_fifo_count != CNT_FULL);
   assign w_push       = i_lu_valid & o_lu_ready;
   assign w_starve_inc = r_starve + STV_ONE;
   assign o_stall_wb   = r_stall_wb;
   assign o_fifo_count = w_fifo_count;

   regfile_write_arbiter_result_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_result_fifo (
      .clock      (clock),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_req (w_lu_req),
      .i_pop      (w_pop),
      .o_empty    (w_fifo_empty),
      .o_count    (w_fifo_count),
      .o_head     (w_fifo_head)
   );

   // Grant selection, starvation accounting and next-state logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_starve_nxt = STV_ZERO;
      w_stall_nxt  = 1'b0;
      w_pop        = 1'b0;
      w_grant      = 1'b0;
      w_grant_req  = WR_REQ_NONE;
      case (r_state)
         NORMAL: begin
            if (w_wb_accept) begin
               w_grant     = 1'b1;
               w_grant_req = w_wb_req;
               if (!w_fifo_empty) begin
                  w_starve_nxt = w_starve_inc;
                  // Head has lost often enough: hold writeback for one cycle.
                  if (w_starve_inc >= STV_TRIP) begin
                     w_state_nxt = FORCE;
                     w_stall_nxt = 1'b1;
                  end else begin
                     w_state_nxt = NORMAL;
                  end
               end else begin
                  w_starve_nxt = STV_ZERO;
               end
            end else if (!w_fifo_empty) begin
               w_grant     = 1'b1;
               w_grant_req = w_fifo_head;
               w_pop       = 1'b1;
            end else begin
               w_grant = 1'b0;
            end
         end
         FORCE: begin
            w_state_nxt = NORMAL;
            if (!w_fifo_empty) begin
               w_grant     = 1'b1;
               w_grant_req = w_fifo_head;
               w_pop       = 1'b1;
            end else begin
               w_grant = 1'b0;
            end
         end
         default: begin
            w_state_nxt = NORMAL;
         end
      endcase
   end

   // Write data to the register file is zeroed whenever no real write happens.
   always_comb begin
      w_out_req = WR_REQ_NONE;
      if (w_grant) begin
         w_out_req = squash_zero(w_grant_req);
      end else begin
         w_out_req = WR_REQ_NONE;
      end
   end

   // Arbitration state and starvation counter.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= NORMAL;
         r_starve   <= STV_ZERO;
         r_stall_wb <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_starve   <= w_starve_nxt;
         r_stall_wb <= w_stall_nxt;
      end
   end

   // Registered register-file write port.
   always_ff @(posedge clock) begin
      if (!reset) begin
         o_rf_we    <= 1'b0;
         o_rf_waddr <= REG_ZERO;
         o_rf_wdata <= 32'h0000_0000;
      end else begin
         o_rf_we    <= w_grant & writes_reg(w_grant_req);
         o_rf_waddr <= w_out_req.addr;
         o_rf_wdata <= w_out_req.data;
      end
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters: the in-order pipeline writeback stage and a buffered queue of results from the long-latency unit (multiply/divide).
- Writeback has priority.
- Long-latency results wait in a small FIFO, with a starvation guard that briefly stalls writeback.
- Outputs are registered and drive the register file write port directly.

Parameters:
- DEPTH, 4, long-latency result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO head may lose arbitration before writeback is forced to stall.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low.
- wb_valid  in  1  writeback has a result this cycle.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- stall_wb  out  1  registered; pipeline must hold its writeback instruction this cycle.
- lu_valid  in  1  long-latency unit offers a result.
- lu_addr  in  5  its destination register.
- lu_data  in  32  its data.
- lu_ready  out  1  FIFO can accept; push = lu_valid & lu_ready.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (clock edge with reset=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0, stall_wb=0, fifo_count=0.
  - FIFO pointers and starve counter cleared, state=NORMAL.
  - Applies mid-operation: queued results are discarded.
- wb_accept = wb_valid & !stall_wb. A held writeback (stall_wb=1) is not consumed; the pipeline re-presents it next cycle.
- lu_ready = (fifo_count != DEPTH), computed from registered count only. A full FIFO is not ready even if popping that cycle.
- A push is visible at the head one cycle later; the head cannot be granted in its push cycle.
- Latency:
  - writeback accepted at t -> rf_* at t+1.
  - long-latency result pushed at t -> earliest rf_* at t+2.
- States NORMAL and FORCE.
- NORMAL:
  - If wb_accept, grant writeback. If FIFO is also non-empty, increment the starve counter. When the counter reaches STARVE_LIMIT-1, go to FORCE and register stall_wb=1.
  - Else if FIFO non-empty, grant head (pop) and clear the counter.
  - Else no grant, rf_we=0.
- FORCE (stall_wb=1 for exactly one cycle):
  - Grant FIFO head (pop), clear counter, return to NORMAL with stall_wb=0.
- Empty FIFO clears the counter every cycle.
- Grant to address 0: request consumed/popped, but rf_we=0, rf_waddr=0, rf_wdata=0.
- Grant to address != 0: rf_we=1, rf_waddr/rf_wdata = granted address/data.
- rf_we=0 cycles also drive rf_waddr=0 and rf_wdata=0.
- Simultaneous push and pop: fifo_count unchanged; pointers wrap modulo DEPTH.
- Ordering between writeback and queued results to the same register is the issuer's responsibility (scoreboard); this block does not reorder within the FIFO.

Decomposition:
- Shared pipeline package holds:
  - REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0.
  - A wr_req typedef {addr, data}.
  - The arbiter state enum {NORMAL, FORCE}.
- One natural sub-module: result_fifo (parameterised DEPTH, synchronous reset, push/pop/count/head outputs).
- Arbitration FSM and output registers stay in the top.

Test Plan:
- Reset check:
  - Stimulus: hold reset=0 two cycles with wb_valid=1, addr=3.
  - Response: rf_we=0, addr/data=0, stall_wb=0, fifo_count=0, lu_ready=1.
- Writeback only:
  - Stimulus: wb_valid=1, addr=5, data=0xDEADBEEF at t.
  - Response: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at t+1.
  - Stimulus: wb_addr=0 at t.
  - Response: rf_we=0 at t+1.
- Long-latency only:
  - Stimulus: push addr=9, data=0x12345678 at t with wb idle.
  - Response: rf_we=1, addr 9, data 0x12345678 at t+2; fifo_count 1 at t+1, 0 at t+2.
- Fill and backpressure:
  - Stimulus: wb_valid=1 continuously, push 4 results.
  - Response: fifo_count=4, lu_ready=0; a fifth lu_valid is not accepted and is held until ready.
- Starvation:
  - Stimulus: FIFO non-empty, wb_valid=1 every cycle.
  - Response: after 7 writeback grants, stall_wb=1 for one cycle; FIFO head written next cycle; held writeback written the cycle after; stall_wb back to 0.
- Reset mid-operation:
  - Stimulus: 3 queued results, assert reset=0 one cycle.
  - Response: fifo_count=0, none of the queued results ever appear on rf_*.
